// File: rtl/reg_file_sb.sv
// reg_file_sb: byte-writable register file with a busy (scoreboard) bit per register.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB      = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NB-1:0]            wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic              wr_ok;
  logic              rsv_ok;

  // Address holds real storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [NB-1:0]     be);
    merge = old_v;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) merge[b*8 +: 8] = new_v[b*8 +: 8];
    end
  endfunction

  assign wr_ok  = wr_en && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && !flush && addr_ok(rsv_addr);

  // Reserve is applied after the write clear so it wins on a shared address.
  always_comb begin
    regs_d = regs_q;
    busy_d = flush ? '0 : busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = merge(regs_q[wr_addr], wr_data, wr_be);
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (addr_ok(rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
          rd_data[k*DATA_W +: DATA_W] = merge(regs_q[rd_addr[k*ADDR_W +: ADDR_W]],
                                              wr_data, wr_be);
          rd_busy[k] = rsv_ok && (rsv_addr == rd_addr[k*ADDR_W +: ADDR_W]);
        end
`endif
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors with hand-computed expectations for reg_file_sb
// in its default configuration (32 x 32-bit, 2 read ports, zero register).
module tb_reg_file_sb;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int ADDR_W = 5;
  localparam int NB     = 4;

  logic                     clk      = 1'b0;
  logic                     rst      = 1'b0;
  logic                     wr_en    = 1'b0;
  logic [ADDR_W-1:0]        wr_addr  = '0;
  logic [NB-1:0]            wr_be    = '0;
  logic [DATA_W-1:0]        wr_data  = '0;
  logic                     rsv_en   = 1'b0;
  logic [ADDR_W-1:0]        rsv_addr = '0;
  logic                     flush    = 1'b0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr  = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W:0]          busy_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  reg_file_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic do_rsv(input logic [ADDR_W-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b1;
    set_rd(5'd0, 5'd31);
    chk("rst0_data0", 64'(rd_data[31:0]), 64'h0);
    chk("rst0_cnt", 64'(busy_cnt), 64'h0);

    // Preload every register to all-ones and mark all busy
    for (int a = 1; a < DEPTH; a++) begin
      do_wr(5'(a), 32'hFFFF_FFFF, 4'b1111);
      do_rsv(5'(a));
      tick();
    end
    idle();
    set_rd(5'd31, 5'd1);
    chk("pre_data0", 64'(rd_data[31:0]), 64'hFFFF_FFFF);
    chk("pre_data1", 64'(rd_data[63:32]), 64'hFFFF_FFFF);
    chk("pre_busy", 64'(rd_busy), 64'h3);
    chk("pre_cnt", 64'(busy_cnt), 64'd31);

    // Reset beats a same-cycle write, reserve and flush
    rst = 1'b0;
    do_wr(5'd5, 32'h1234_5678, 4'b1111);
    do_rsv(5'd6);
    flush = 1'b1;
    tick();
    rst = 1'b1;
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(5'(a), 5'(DEPTH - 1 - a));
      chk("rst_data0", 64'(rd_data[31:0]), 64'h0);
      chk("rst_data1", 64'(rd_data[63:32]), 64'h0);
      chk("rst_busy", 64'(rd_busy), 64'h0);
    end
    chk("rst_cnt", 64'(busy_cnt), 64'h0);

    // Byte-enable merging
    do_wr(5'd5, 32'hDEAD_BEEF, 4'b1111);
    tick();
    idle();
    set_rd(5'd5, 5'd5);
    chk("be_full", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    do_wr(5'd5, 32'h0000_00AA, 4'b0001);
    tick();
    idle();
    set_rd(5'd5, 5'd5);
    chk("be_low_p0", 64'(rd_data[31:0]), 64'hDEAD_BEAA);
    chk("be_low_p1", 64'(rd_data[63:32]), 64'hDEAD_BEAA);
    do_wr(5'd5, 32'h5566_7788, 4'b1010);
    tick();
    idle();
    set_rd(5'd5, 5'd4);
    chk("be_mixed", 64'(rd_data[31:0]), 64'h55AD_77AA);
    chk("other_reg", 64'(rd_data[63:32]), 64'h0);

    // Reserve / write interaction on r7
    do_rsv(5'd7);
    tick();
    idle();
    set_rd(5'd7, 5'd6);
    chk("rsv7_busy", 64'(rd_busy), 64'h1);
    chk("rsv7_cnt", 64'(busy_cnt), 64'd1);
    do_wr(5'd7, 32'h0000_0077, 4'b1111);
    do_rsv(5'd7);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    chk("wrrsv7_busy", 64'(rd_busy), 64'h3);
    chk("wrrsv7_cnt", 64'(busy_cnt), 64'd1);
    chk("wrrsv7_data", 64'(rd_data[31:0]), 64'h77);
    do_wr(5'd7, 32'h0000_0088, 4'b0001);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    chk("wr7_busy", 64'(rd_busy), 64'h0);
    chk("wr7_cnt", 64'(busy_cnt), 64'd0);
    chk("wr7_data", 64'(rd_data[31:0]), 64'h88);

    // Zero register ignores writes and reserves
    do_wr(5'd0, 32'h1234_5678, 4'b1111);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    chk("r0_data", 64'(rd_data), 64'h0);
    do_rsv(5'd0);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    chk("r0_cnt", 64'(busy_cnt), 64'd0);
    chk("r0_busy", 64'(rd_busy), 64'h0);

    // Flush clears everything and blocks a same-cycle reserve, write still lands
    for (int a = 1; a <= 4; a++) begin
      do_rsv(5'(a));
      tick();
    end
    idle();
    set_rd(5'd2, 5'd9);
    chk("r1_4_cnt", 64'(busy_cnt), 64'd4);
    chk("r1_4_busy", 64'(rd_busy), 64'h1);
    flush = 1'b1;
    do_rsv(5'd9);
    do_wr(5'd2, 32'h0000_ABCD, 4'b1111);
    tick();
    idle();
    set_rd(5'd2, 5'd9);
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    chk("flush_busy", 64'(rd_busy), 64'h0);
    chk("flush_wr", 64'(rd_data[31:0]), 64'h0000_ABCD);

    // Write and reserve on different registers in one cycle
    do_wr(5'd10, 32'h1010_1010, 4'b1111);
    do_rsv(5'd11);
    tick();
    idle();
    set_rd(5'd10, 5'd11);
    chk("split_busy", 64'(rd_busy), 64'h2);
    chk("split_cnt", 64'(busy_cnt), 64'd1);
    chk("split_data", 64'(rd_data), {32'h0, 32'h1010_1010});

    // Same-cycle visibility of a write (forwarding vs. registered read)
    do_rsv(5'd3);
    tick();
    idle();
    set_rd(5'd3, 5'd11);
    chk("r3_cnt", 64'(busy_cnt), 64'd2);
    do_wr(5'd3, 32'hCAFE_F00D, 4'b1111);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_data", 64'(rd_data[31:0]), 64'hCAFE_F00D);
    chk("byp_busy", 64'(rd_busy), 64'h2);
`else
    chk("nobyp_data", 64'(rd_data[31:0]), 64'h0);
    chk("nobyp_busy", 64'(rd_busy), 64'h3);
`endif
    chk("byp_other", 64'(rd_data[63:32]), 64'h0);
    tick();
    idle();
    #1;
    chk("r3_next_data", 64'(rd_data[31:0]), 64'hCAFE_F00D);
    chk("r3_next_busy", 64'(rd_busy), 64'h2);
    chk("r3_next_cnt", 64'(busy_cnt), 64'd1);
    do_wr(5'd3, 32'h0000_5500, 4'b0010);
    do_rsv(5'd3);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_part_data", 64'(rd_data[31:0]), 64'hCAFE_550D);
    chk("byp_part_busy", 64'(rd_busy), 64'h3);
`else
    chk("nobyp_part_data", 64'(rd_data[31:0]), 64'hCAFE_F00D);
    chk("nobyp_part_busy", 64'(rd_busy), 64'h2);
`endif
    tick();
    idle();
    #1;
    chk("part_next_data", 64'(rd_data[31:0]), 64'hCAFE_550D);
    chk("part_next_busy", 64'(rd_busy), 64'h3);
    chk("part_next_cnt", 64'(busy_cnt), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
